// File: rtl/puerto_lectura_pkg.sv
// rtl/puerto_lectura_pkg.sv - shared address offsets and interrupt state encoding
package puerto_lectura_pkg;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_t;

  // Offsets relative to BASE_ID; they follow the data registers.
  function automatic logic [7:0] ofs_status(input int n_src);
    return 8'(n_src);
  endfunction

  function automatic logic [7:0] ofs_overrun(input int n_src);
    return 8'(n_src + 1);
  endfunction

endpackage

// File: rtl/puerto_lectura_celda.sv
// rtl/puerto_lectura_celda.sv - per-source byte register with pending and overrun flags
module celda_fuente (
  input  logic       clk,
  input  logic       rst,
  input  logic       captura,
  input  logic [7:0] dato_in,
  input  logic       limpia_pending,
  input  logic       limpia_overrun,
  output logic [7:0] dato,
  output logic       pending,
  output logic       overrun
);

  // A read of this byte in the capture cycle consumes the old byte, so no overrun.
  logic pone_overrun;
  assign pone_overrun = captura && pending && !limpia_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dato    <= 8'h00;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (captura) begin
        dato    <= dato_in;
        pending <= 1'b1;
      end else if (limpia_pending) begin
        pending <= 1'b0;
      end
      if (pone_overrun) begin
        overrun <= 1'b1;
      end else if (limpia_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/puerto_lectura.sv
// rtl/puerto_lectura.sv - input port block: address decode, registered read mux, interrupt FSM
module puerto_lectura
  import puerto_lectura_pkg::*;
#(
  parameter int         N_SRC   = 4,
  parameter logic [7:0] BASE_ID = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               read_strobe,
  input  logic [7:0]         port_id,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic               interrupt_ack,
  output logic [7:0]         port_in,
  output logic               interrupt,
  output logic [N_SRC-1:0]   pending
);

  logic [7:0]       dato [N_SRC];
  logic [N_SRC-1:0] overrun;
  logic [7:0]       ofs;
  logic             lectura;
  logic             hit_overrun;
  logic [7:0]       rd_mux;
  irq_state_t       state_q, state_d;

  // Addresses below BASE_ID wrap to large offsets and decode as unmapped.
  assign ofs         = port_id - BASE_ID;
  assign lectura     = en && read_strobe;
  assign hit_overrun = (ofs == ofs_overrun(N_SRC));

  for (genvar i = 0; i < N_SRC; i++) begin : g_celda
    celda_fuente u_celda (
      .clk            (clk),
      .rst            (rst),
      .captura        (src_valid[i]),
      .dato_in        (src_data[8*i +: 8]),
      .limpia_pending (lectura && (ofs == 8'(i))),
      .limpia_overrun (lectura && hit_overrun),
      .dato           (dato[i]),
      .pending        (pending[i]),
      .overrun        (overrun[i])
    );
  end

  always_comb begin
    rd_mux = 8'h00;
    for (int i = 0; i < N_SRC; i++) begin
      if (ofs == 8'(i)) rd_mux = dato[i];
    end
    if (ofs == ofs_status(N_SRC)) rd_mux = 8'(pending);
    if (hit_overrun)              rd_mux = 8'(overrun);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_in <= 8'h00;
      state_q <= IRQ_IDLE;
    end else begin
      port_in <= rd_mux;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    interrupt = 1'b0;
    case (state_q)
      IRQ_IDLE: if (|src_valid) state_d = IRQ_REQ;
      IRQ_REQ: begin
        interrupt = 1'b1;
        if (interrupt_ack && !(|src_valid)) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_puerto_lectura.sv
// tb/tb_puerto_lectura.sv - directed self-checking bench for puerto_lectura
module tb_puerto_lectura;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        read_strobe = 1'b0;
  logic [7:0]  port_id = 8'h00;
  logic [31:0] src_data = '0;
  logic [3:0]  src_valid = '0;
  logic        interrupt_ack = 1'b0;
  logic [7:0]  port_in;
  logic        interrupt;
  logic [3:0]  pending;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] dat;

  puerto_lectura #(.N_SRC(4), .BASE_ID(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .read_strobe   (read_strobe),
    .port_id       (port_id),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .interrupt_ack (interrupt_ack),
    .port_in       (port_in),
    .interrupt     (interrupt),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic chequea(input string tag, input logic [7:0] obs, input logic [7:0] esp);
    n_vec++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic captura(input int idx, input logic [7:0] b);
    src_data[idx*8 +: 8] = b;
    src_valid[idx] = 1'b1;
    ciclo();
    src_valid = '0;
  endtask

  // port_id held two cycles, strobe in the second; data is what the processor samples.
  task automatic lee(input logic [7:0] id, output logic [7:0] d);
    port_id = id;
    read_strobe = 1'b0;
    ciclo();
    d = port_in;
    read_strobe = 1'b1;
    ciclo();
    read_strobe = 1'b0;
  endtask

  initial begin
    ciclo();
    chequea("reset_port_in", port_in, 8'h00);
    chequea("reset_irq", {7'b0, interrupt}, 8'h00);
    chequea("reset_pending", {4'b0, pending}, 8'h00);
    rst = 1'b1;
    ciclo();

    captura(1, 8'hA5);
    chequea("cap_pending", {4'b0, pending}, 8'h02);
    chequea("cap_irq", {7'b0, interrupt}, 8'h01);
    lee(8'h01, dat);
    chequea("rd_data1", dat, 8'hA5);
    chequea("rd_clr_pending", {4'b0, pending}, 8'h00);
    interrupt_ack = 1'b1;
    ciclo();
    interrupt_ack = 1'b0;
    chequea("ack_irq_low", {7'b0, interrupt}, 8'h00);

    captura(2, 8'h11);
    captura(2, 8'h22);
    chequea("ovr_pending", {4'b0, pending}, 8'h04);
    lee(8'h05, dat);
    chequea("ovr_read", dat, 8'h04);
    lee(8'h05, dat);
    chequea("ovr_cleared", dat, 8'h00);
    lee(8'h02, dat);
    chequea("ovr_data", dat, 8'h22);

    captura(0, 8'h10);
    port_id = 8'h00;
    ciclo();
    dat = port_in;
    read_strobe = 1'b1;
    src_data[7:0] = 8'h3C;
    src_valid[0] = 1'b1;
    ciclo();
    read_strobe = 1'b0;
    src_valid = '0;
    chequea("col_old_byte", dat, 8'h10);
    chequea("col_pending", {4'b0, pending}, 8'h01);
    lee(8'h05, dat);
    chequea("col_no_ovr", dat, 8'h00);
    lee(8'h00, dat);
    chequea("col_new_byte", dat, 8'h3C);
    chequea("col_pend_clr", {4'b0, pending}, 8'h00);

    chequea("irq_before_ack", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 1'b1;
    captura(3, 8'h77);
    interrupt_ack = 1'b0;
    chequea("ack_with_cap", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 1'b1;
    ciclo();
    interrupt_ack = 1'b0;
    chequea("lone_ack", {7'b0, interrupt}, 8'h00);

    lee(8'h40, dat);
    chequea("unmapped", dat, 8'h00);
    lee(8'h04, dat);
    chequea("status", dat, 8'h08);

    captura(0, 8'h55);
    en = 1'b0;
    lee(8'h00, dat);
    en = 1'b1;
    chequea("en0_data", dat, 8'h55);
    chequea("en0_pending", {4'b0, pending}, 8'h09);

    src_data[15:8] = 8'h99;
    src_valid[1] = 1'b1;
    ciclo();
    ciclo();
    src_valid = '0;
    lee(8'h05, dat);
    chequea("held_valid_ovr", dat, 8'h02);

    port_id = 8'h04;
    ciclo();
    chequea("pre_reset_status", port_in, 8'h0B);
    #2 rst = 1'b0;
    #1;
    chequea("async_port_in", port_in, 8'h00);
    chequea("async_irq", {7'b0, interrupt}, 8'h00);
    chequea("async_pending", {4'b0, pending}, 8'h00);
    ciclo();
    rst = 1'b1;
    captura(2, 8'hC3);
    lee(8'h02, dat);
    chequea("post_reset_data", dat, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/puerto_lectura.md
# puerto_lectura

Input-port block for the soft processor's I/O bus. It is the read-side counterpart of the write-port data registers: peripherals hand it bytes, and it holds them with pending and overrun flags. It presents the byte selected by `port_id` on `port_in`, applies clear-on-read side effects when the processor performs an `INPUT`, and raises a held interrupt request until the processor acknowledges it.

## Interface
Parameters:
- `N_SRC`, 4: number of peripheral byte sources (1..8).
- `BASE_ID`, 8'h00: first port address. Data registers sit at `BASE_ID`..`BASE_ID+N_SRC-1`, status at `BASE_ID+N_SRC`, overrun at `BASE_ID+N_SRC+1`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: block select; read side effects occur only when high.
- `read_strobe` in 1: processor read strobe, one cycle per `INPUT`.
- `port_id` in 8: processor port address.
- `src_data` in 8*N_SRC: source bytes; source i is on bits [8i+7:8i].
- `src_valid` in N_SRC: one-cycle capture strobe per source.
- `interrupt_ack` in 1: processor interrupt acknowledge.
- `port_in` out 8: registered read data to the processor.
- `interrupt` out 1: interrupt request, held until acknowledged.
- `pending` out N_SRC: pending flags, exported for debug and LEDs.

## Operation
- Capture: `src_valid[i]` loads `dato[i]` from the source byte and sets `pending[i]`. If `pending[i]` was already 1, it also sets `overrun[i]`.
- Read mux, registered every cycle:
  - Data address i: `port_in <= dato[i]`.
  - Status address: `port_in <= {zero-pad, pending}`.
  - Overrun address: `port_in <= {zero-pad, overrun}`.
  - Any other `port_id`: `port_in <= 8'h00`.
- Read side effects, only when `en && read_strobe`, decoded from the current `port_id`:
  - Data address i: clears `pending[i]`.
  - Overrun address: clears all overrun bits.
  - Status address: no side effect.
- Same-cycle capture and read of index i: capture wins. `pending[i]` stays 1, `dato[i]` takes the new byte, `overrun[i]` is not set. The processor gets the old byte; the new byte stays pending.
- Same-cycle capture into i and read of the overrun address: the new overrun set wins for bit i; all other bits clear.
- Interrupt FSM, two states:
  - IDLE to REQ: any `src_valid[i]` while in IDLE.
  - REQ to IDLE: `interrupt_ack`, unless any `src_valid` occurs in the same cycle (then it stays in REQ).
  - `interrupt` is 1 exactly in REQ.
- Reset values: `dato`, `pending`, `overrun` and `port_in` all 0; FSM in IDLE; `interrupt` = 0.

## Timing
- Capture latency: 1 cycle. `pending` and `dato` update on the edge that samples `src_valid`.
- Read latency: `port_in` reflects `port_id` one cycle after `port_id` changes.
  - The processor holds `port_id` for 2 cycles and asserts `read_strobe` in the second, so data is valid when sampled.
- Side effects take place on the edge that samples `read_strobe`. `port_in` for that read is unaffected because it was registered one cycle earlier.
- Interrupt latency: `interrupt` rises 1 cycle after `src_valid` and falls 1 cycle after `interrupt_ack`.
- Reset asserted mid-operation clears all state immediately (asynchronous). Captures and reads resume on the first edge after `rst` deasserts.
- `src_valid` held high for several cycles counts as one capture per cycle. The second such cycle sets overrun.

## Structure
- Shared package holds:
  - address offset constants: `OFS_STATUS` = N_SRC, `OFS_OVERRUN` = N_SRC+1;
  - the interrupt state encoding: `IRQ_IDLE` = 0, `IRQ_REQ` = 1.
- Natural sub-module: `celda_fuente`, one instance per source, containing `dato`, `pending` and `overrun` with the capture and clear logic.
- The top level contains the address decode, the registered read mux and the interrupt FSM.

## Test plan
- Reset: drive `rst`=0 mid-run. Required response: `port_in`=00, `interrupt`=0, `pending`=0 immediately.
- Capture and read:
  - `src_valid[1]` with byte 8'hA5 gives `pending`=4'b0010 and `interrupt`=1 one cycle later.
  - With `port_id`=8'h01 for 2 cycles and `read_strobe` in the second, the processor samples A5 and `pending` becomes 0.
- Overrun: two `src_valid[2]` captures (8'h11, then 8'h22) with no read between. Required response:
  - reading `port_id`=8'h05 returns 8'h04;
  - a second read of 8'h05 returns 8'h00;
  - reading the data register at 8'h02 returns 8'h22.
- Collision: `src_valid[0]` with byte 8'h3C in the same cycle as a read of 8'h00 that holds old byte 8'h10. Required response: the processor gets 10, `pending[0]` stays 1, and the next read returns 3C.
- Interrupt handshake:
  - `interrupt_ack` together with a new `src_valid[3]` keeps `interrupt`=1.
  - A lone `interrupt_ack` drops `interrupt` on the next cycle.
- Decode and enable:
  - `port_id`=8'h40 returns 00.
  - A read of 8'h00 with `en`=0 leaves `pending[0]` set.
